// File: rtl/game_pkg.sv
// Shared game types and screen geometry used by the sprite controllers.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package game_pkg;

    localparam int SCREEN_W         = 640;
    localparam int SCREEN_H         = 480;
    localparam int COORD_W          = 10;
    localparam int PLAYER_Y_DEFAULT = 150;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } bullet_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame pulse into the Clk domain and emits a one-cycle tick per frame.
// Latency: tick is high in the cycle after the 2nd Clk edge that samples frame_clk high.
// Backpressure: none; every frame produces exactly one tick.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync_1;
    logic sync_2;
    logic sync_2_q;

    // Two-flop synchronizer followed by a history flop for rising-edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_2_q <= 1'b0;
        end else begin
            sync_1   <= frame_clk;
            sync_2   <= sync_1;
            sync_2_q <= sync_2;
        end
    end

    assign tick = sync_2 & ~sync_2_q;

endmodule

// File: rtl/bullet_controller.sv
// Sequences the player's single bullet: spawn on fire press, climb once per frame, retire at top or on hit.
// Latency: spawn visible one cycle after fire is first sampled high; moves on the 3rd Clk edge after frame_clk rises.
// Backpressure: none; fire presses while a bullet is live (or cooling down) are dropped, never queued.
// Build option BULLET_COOLDOWN_EN adds a frame-counted cooldown between retirement and the next shot.
module bullet_controller
    import game_pkg::*;
#(
    parameter int PLAYER_Y        = PLAYER_Y_DEFAULT,
    parameter int BULLET_LEN      = 4,
    parameter int BULLET_STEP     = 4,
    parameter int Y_TOP           = 0,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               fire,
    input  logic               hit,
    input  logic [COORD_W-1:0] playerX,
    output logic               bullet_in,
    output logic [COORD_W-1:0] bulletX,
    output logic [COORD_W-1:0] bulletY,
    output logic               shot_fired
);

    localparam logic [COORD_W-1:0] SPAWN_Y   = COORD_W'(PLAYER_Y - BULLET_LEN);
    localparam logic [COORD_W-1:0] TOP_LIMIT = COORD_W'(Y_TOP + BULLET_STEP);
    localparam logic [COORD_W-1:0] STEP      = COORD_W'(BULLET_STEP);

    bullet_state_t      state;
    bullet_state_t      state_nxt;
    logic               tick;
    logic               fire_q;
    logic               fire_edge;
    logic               retire;
    logic               bullet_in_nxt;
    logic               shot_nxt;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;

`ifdef BULLET_COOLDOWN_EN
    localparam int              CNT_W    = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
`else
    // No counter in this build; COOLDOWN_FRAMES is accepted but has no effect.
    if (COOLDOWN_FRAMES < 0) begin : g_cooldown_unused
    end
`endif

    frame_tick_gen u_frame_tick_gen (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Register the fire press edge so playerX is taken one cycle after fire is first seen.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fire_q    <= 1'b0;
            fire_edge <= 1'b0;
        end else begin
            fire_q    <= fire;
            fire_edge <= fire & ~fire_q;
        end
    end

    // Next-state and next-output decode; hit outranks tick, top compare precedes the subtract.
    always_comb begin
        state_nxt     = state;
        bullet_in_nxt = bullet_in;
        x_nxt         = bulletX;
        y_nxt         = bulletY;
        shot_nxt      = 1'b0;
        retire        = 1'b0;
`ifdef BULLET_COOLDOWN_EN
        cnt_nxt       = cnt;
`endif
        case (state)
            IDLE: begin
                if (fire_edge) begin
                    state_nxt     = FLIGHT;
                    bullet_in_nxt = 1'b1;
                    x_nxt         = playerX;
                    y_nxt         = SPAWN_Y;
                    shot_nxt      = 1'b1;
                end
            end
            FLIGHT: begin
                if (hit) begin
                    retire = 1'b1;
                end else if (tick) begin
                    if (bulletY < TOP_LIMIT) begin
                        retire = 1'b1;
                    end else begin
                        y_nxt = bulletY - STEP;
                    end
                end
            end
`ifdef BULLET_COOLDOWN_EN
            COOLDOWN: begin
                if (tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Retiring keeps the last coordinates so the renderer sees a stable position.
        if (retire) begin
            bullet_in_nxt = 1'b0;
`ifdef BULLET_COOLDOWN_EN
            state_nxt     = COOLDOWN;
            cnt_nxt       = CNT_LOAD;
`else
            state_nxt     = IDLE;
`endif
        end
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            bullet_in  <= 1'b0;
            bulletX    <= '0;
            bulletY    <= '0;
            shot_fired <= 1'b0;
`ifdef BULLET_COOLDOWN_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            bullet_in  <= bullet_in_nxt;
            bulletX    <= x_nxt;
            bulletY    <= y_nxt;
            shot_fired <= shot_nxt;
`ifdef BULLET_COOLDOWN_EN
            cnt        <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed and randomized bench for bullet_controller against a frame-level behavioural model.
// Latency: model applies fire one edge after first sample and frame ticks on the 3rd edge after rise.
// Backpressure: none; inputs are driven freely on the falling edge.
module tb_bullet_controller;

    localparam int PY   = 150;
    localparam int BL   = 4;
    localparam int STEP = 4;
    localparam int YTOP = 0;
    localparam int CD   = 8;
`ifdef BULLET_COOLDOWN_EN
    localparam int CD_ON = 1;
`else
    localparam int CD_ON = 0;
`endif

    logic       Clk       = 1'b0;
    logic       Reset     = 1'b1;
    logic       frame_clk = 1'b0;
    logic       fire      = 1'b0;
    logic       hit       = 1'b0;
    logic [9:0] playerX   = 10'd0;
    logic       bullet_in;
    logic [9:0] bulletX;
    logic [9:0] bulletY;
    logic       shot_fired;

    int checks   = 0;
    int failures = 0;
    int shot_cnt = 0;

    bullet_controller #(
        .PLAYER_Y        (PY),
        .BULLET_LEN      (BL),
        .BULLET_STEP     (STEP),
        .Y_TOP           (YTOP),
        .COOLDOWN_FRAMES (CD)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .fire       (fire),
        .hit        (hit),
        .playerX    (playerX),
        .bullet_in  (bullet_in),
        .bulletX    (bulletX),
        .bulletY    (bulletY),
        .shot_fired (shot_fired)
    );

    always #5 Clk = ~Clk;

    // Count shot pulses shortly after each rising edge.
    always @(posedge Clk) begin
        #2;
        if (shot_fired) shot_cnt++;
    end

    // Behavioural model: input histories give the press edge and frame tick, rules give the motion.
    logic [1:0] fire_hist;
    logic [2:0] frame_hist;
    logic       m_active;
    logic       m_shot;
    int         m_x;
    int         m_y;
    int         m_cool;
    wire        m_fe = fire_hist[0] & ~fire_hist[1];
    wire        m_tk = frame_hist[1] & ~frame_hist[2];

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fire_hist  <= '0;
            frame_hist <= '0;
            m_active   <= 1'b0;
            m_shot     <= 1'b0;
            m_x        <= 0;
            m_y        <= 0;
            m_cool     <= 0;
        end else begin
            fire_hist  <= {fire_hist[0], fire};
            frame_hist <= {frame_hist[1:0], frame_clk};
            m_shot     <= 1'b0;
            if (m_active) begin
                if (hit || (m_tk && m_y < YTOP + STEP)) begin
                    m_active <= 1'b0;
                    m_cool   <= CD_ON ? CD : 0;
                end else if (m_tk) begin
                    m_y <= m_y - STEP;
                end
            end else if (m_cool > 0) begin
                if (m_tk) m_cool <= m_cool - 1;
            end else if (m_fe) begin
                m_active <= 1'b1;
                m_x      <= int'(playerX);
                m_y      <= PY - BL;
                m_shot   <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fire_pulse();
        @(negedge Clk) fire = 1'b1;
        @(negedge Clk) fire = 1'b0;
        @(negedge Clk);
    endtask

    task automatic frame_pulse();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk) frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // Frame pulse with hit raised in exactly the cycle the tick is seen.
    task automatic frame_pulse_hit();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk) begin
            frame_clk = 1'b0;
            hit       = 1'b1;
        end
        @(negedge Clk) hit = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int shots0;
        int frame_left;

        // Reset state
        repeat (3) @(negedge Clk);
        check("reset_bullet_in", 32'(bullet_in), 32'd0);
        check("reset_bulletX", 32'(bulletX), 32'd0);
        check("reset_bulletY", 32'(bulletY), 32'd0);
        check("reset_shot", 32'(shot_fired), 32'd0);
        Reset = 1'b0;

        // Spawn
        @(negedge Clk) begin
            playerX = 10'd320;
            fire    = 1'b1;
        end
        @(negedge Clk) fire = 1'b0;
        check("pre_spawn_bullet_in", 32'(bullet_in), 32'd0);
        @(negedge Clk);
        check("spawn_bullet_in", 32'(bullet_in), 32'd1);
        check("spawn_bulletX", 32'(bulletX), 32'd320);
        check("spawn_bulletY", 32'(bulletY), 32'd146);
        check("spawn_shot", 32'(shot_fired), 32'd1);
        @(negedge Clk);
        check("shot_one_cycle", 32'(shot_fired), 32'd0);

        // Re-press during flight is ignored
        shots0  = shot_cnt;
        playerX = 10'd100;
        fire_pulse();
        repeat (2) @(negedge Clk);
        check("flight_repress_x", 32'(bulletX), 32'd320);
        check("flight_repress_shots", 32'(shot_cnt - shots0), 32'd0);

        // Travel to the top and retire
        frame_pulse();
        check("tick1_y", 32'(bulletY), 32'd142);
        repeat (35) frame_pulse();
        check("tick36_y", 32'(bulletY), 32'd2);
        check("tick36_in", 32'(bullet_in), 32'd1);
        frame_pulse();
        check("tick37_in", 32'(bullet_in), 32'd0);
        check("tick37_y_hold", 32'(bulletY), 32'd2);
        check("tick37_x_hold", 32'(bulletX), 32'd320);

        // After retirement: cooldown blocks presses (if built), then a press spawns
        playerX = 10'd200;
`ifdef BULLET_COOLDOWN_EN
        shots0 = shot_cnt;
        for (int t = 1; t <= 7; t++) begin
            frame_pulse();
            fire_pulse();
            check("cooldown_no_spawn", 32'(bullet_in), 32'd0);
        end
        check("cooldown_no_shots", 32'(shot_cnt - shots0), 32'd0);
        frame_pulse();
`endif
        shots0 = shot_cnt;
        fire_pulse();
        check("respawn_in", 32'(bullet_in), 32'd1);
        check("respawn_x", 32'(bulletX), 32'd200);
        check("respawn_y", 32'(bulletY), 32'd146);
        check("respawn_shots", 32'(shot_cnt - shots0), 32'd1);

        // Hit and tick together: hit wins, no final move
        repeat (11) frame_pulse();
        check("pre_hit_y", 32'(bulletY), 32'd102);
        frame_pulse_hit();
        check("hit_in", 32'(bullet_in), 32'd0);
        check("hit_y_hold", 32'(bulletY), 32'd102);
        check("hit_x_hold", 32'(bulletX), 32'd200);

        // Hit outside flight changes nothing
        @(negedge Clk) hit = 1'b1;
        @(negedge Clk) hit = 1'b0;
        @(negedge Clk);
        check("idle_hit_in", 32'(bullet_in), 32'd0);
        check("idle_hit_y", 32'(bulletY), 32'd102);
`ifdef BULLET_COOLDOWN_EN
        repeat (8) frame_pulse();
`endif

        // Held fire gives exactly one shot
        shots0 = shot_cnt;
        @(negedge Clk) begin
            playerX = 10'd77;
            fire    = 1'b1;
        end
        repeat (200) frame_pulse();
        check("held_one_shot", 32'(shot_cnt - shots0), 32'd1);
        check("held_retired", 32'(bullet_in), 32'd0);
        check("held_top_y", 32'(bulletY), 32'd2);
        @(negedge Clk) fire = 1'b0;

        // Asynchronous reset mid-flight
        playerX = 10'd400;
        fire_pulse();
        repeat (21) frame_pulse();
        check("pre_reset_y", 32'(bulletY), 32'd62);
        check("pre_reset_in", 32'(bullet_in), 32'd1);
        check("pre_reset_x", 32'(bulletX), 32'd400);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_in", 32'(bullet_in), 32'd0);
        check("async_reset_x", 32'(bulletX), 32'd0);
        check("async_reset_y", 32'(bulletY), 32'd0);
        @(negedge Clk) Reset = 1'b0;
        fire_pulse();
        check("post_reset_spawn_in", 32'(bullet_in), 32'd1);
        check("post_reset_spawn_y", 32'(bulletY), 32'd146);

        // Randomized traffic compared every cycle against the model
        frame_left = 3;
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            check("rand_bullet_in", 32'(bullet_in), 32'(m_active));
            check("rand_bulletX", 32'(bulletX), 32'(m_x));
            check("rand_bulletY", 32'(bulletY), 32'(m_y));
            check("rand_shot", 32'(shot_fired), 32'(m_shot));
            if ($urandom_range(0, 5) == 0) fire = ~fire;
            hit = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 15) == 0) playerX = 10'($urandom_range(0, 639));
            if (frame_left == 0) begin
                frame_clk  = ~frame_clk;
                frame_left = $urandom_range(1, 6);
            end else begin
                frame_left--;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
